dmem_port_sched: RTL and testbench
==================================

# dmem_port_sched

Round-robin access scheduler for one direction (store or load) of the TPU data memory. It arbitrates among the lane requesters and the external router requester, then latches the winner's length, stride and base address. It issues a one-cycle configuration pulse to the address generator, counts accepted beats until the transfer is done, and releases the grant. One instance serves the store side and one serves the load side of the data memory.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters. Index 0 is lane 1, index 1 is lane 2, index 2 is the external router port.
- WDOG_CYCLES, 256, idle-beat limit. Used only when the watchdog is compiled in.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- I_Req  in  NUM_REQ  level request per requester; held until that requester's grant is seen.
- I_Length  in  NUM_REQ x address_t  beat count per requester.
- I_Stride  in  NUM_REQ x address_t  stride per requester.
- I_Base_Addr  in  NUM_REQ x address_t  base address per requester.
- I_Beat  in  1  one beat accepted by memory this cycle (valid & granted).
- O_Grant  out  NUM_REQ  one-hot grant; held from GRANT through RELEASE.
- O_GrantVld  out  1  OR of O_Grant.
- O_GrantNo  out  2  index of the granted requester.
- O_Length  out  address_t  latched length of the winner.
- O_Stride  out  address_t  latched stride of the winner.
- O_Base_Addr  out  address_t  latched base address of the winner.
- O_Start  out  1  one-cycle configuration pulse to the address generator.
- O_End  out  1  one-cycle termination pulse; also the I_Term input for the requesters.
- O_Busy  out  1  high in any state other than IDLE.
- O_Abort  out  1  one-cycle watchdog abort pulse.

## Operation
States: IDLE, GRANT, RUN, RELEASE.

- **IDLE:** if any I_Req is high, pick a winner by round robin starting at the index ptr, then go to GRANT. Latch the winner's index, length, stride and base. Otherwise stay in IDLE.
- **GRANT:** assert O_Start for this cycle only and clear the beat counter.
  - If the latched length is 0, go to RELEASE.
  - Otherwise go to RUN.
- **RUN:** count I_Beat. When I_Beat is high and count == length-1, go to RELEASE.
- **RELEASE:** assert O_End. Set ptr = (granted index + 1) mod NUM_REQ. Go to IDLE.

Behaviour rules:
- Round robin: the first requester at or after ptr (cyclic) wins.
- Changes to requests and to I_Length/I_Stride/I_Base_Addr are ignored outside IDLE. A requester that drops I_Req while granted does not cancel its transfer.
- I_Beat is ignored in IDLE and GRANT, so no count occurs outside RUN.
- The beat counter is address_t wide and never wraps, because it leaves RUN at length-1.

Reset values:
- All outputs are 0.
- ptr is 0, the state is IDLE and the counter is 0.
- Reset during any state aborts the transfer immediately. No O_End is produced.

## Timing
- I_Req rises in IDLE at cycle t. At t+1 the state is GRANT: O_Grant, O_GrantVld, O_GrantNo, the latched configuration and O_Start are all valid. RUN begins at t+2.
- The last beat at cycle u gives RELEASE at u+1 (O_End high and grant still high). At u+2 the state is IDLE with the grant low.
- The earliest next grant is at u+3, so there is one dead cycle between transfers.
- All outputs are registered or decoded only from registered state; there are no combinational paths from inputs to outputs.

## Configuration
DMEM_SCHED_WATCHDOG_EN:
- **Defined:** in RUN, an idle counter increments on every cycle without I_Beat and clears on each beat.
  - When it reaches WDOG_CYCLES-1 with no beat, go to RELEASE and pulse O_Abort together with O_End.
  - ptr advances as for a normal release.
- **Undefined:** there is no idle counter, O_Abort is tied to 0, and a transfer with a stalled memory waits forever.

## Structure
- pkg_tpu holds:
  - `sched_state_t`, an enum with IDLE, GRANT, RUN and RELEASE.
  - `NUM_DMEM_REQ = 3`.
  - The existing `address_t`.
- Sub-module dmem_rr_pick: a combinational cyclic priority pick taking the request vector and ptr, producing a valid flag and an index. It is instantiated once.

## Test plan
- **Single transfer:** I_Req=3'b001 with length 4 and four I_Beat in RUN gives O_Start at t+1, O_End one cycle after the fourth beat, O_GrantNo=0 throughout, and then ptr=1.
- **Round robin:** I_Req=3'b111 held for three transfers gives grants in order 0, 1, 2. Restarting after ptr=1 with I_Req=3'b101 grants 2.
- **Zero length:** a grant with length 0 gives GRANT then RELEASE on consecutive cycles, and I_Beat is never counted.
- **Stray beats:** I_Beat pulses in IDLE and GRANT leave the counter unchanged, and the transfer still needs exactly length beats in RUN.
- **Reset mid-RUN:** reset after two of five beats puts every output at 0 and ptr at 0 on the next cycle, with no O_End pulse.
- **Watchdog (only with DMEM_SCHED_WATCHDOG_EN, WDOG_CYCLES=8):** eight RUN cycles without a beat give O_Abort and O_End together, followed by IDLE.

Source files
------------

// File: rtl/dmem_port_sched_pkg.sv
// Shared TPU data-memory types: the address word, the scheduler state
// enumeration and the number of data-memory requesters per direction.
package pkg_tpu;

   typedef logic [31:0] address_t;

   localparam int NUM_DMEM_REQ = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RUN     = 2'd2,
      RELEASE = 2'd3
   } sched_state_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational cyclic priority pick: the first requester at or after the
// pointer (wrapping around) wins. Index 0 is lane 1, 1 is lane 2 and
// 2 is the external router port.
module dmem_rr_pick #(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [1:0]         ptr_i,
   output logic               valid_o,
   output logic [1:0]         idx_o
);

   int          j;
   logic [1:0]  jIdx;

   // Scan from the farthest offset down to offset zero so the requester
   // closest to the pointer overwrites any later one and wins.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = 2'd0;
      j       = 0;
      jIdx    = 2'd0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = int'(ptr_i) + k;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end
         jIdx = 2'(j);
         if (req_i[jIdx]) begin
            valid_o = 1'b1;
            idx_o   = jIdx;
         end
      end
   end

endmodule

// File: rtl/dmem_port_sched.sv
// Round-robin access scheduler for one direction of the TPU data memory.
// Grants one requester, latches its length/stride/base, pulses O_Start to
// the address generator, counts accepted beats and pulses O_End on release.
// Optional feature macro: DMEM_SCHED_WATCHDOG_EN adds an idle-beat watchdog
// that aborts a transfer after WDOG_CYCLES stalled RUN cycles.
module dmem_port_sched
   import pkg_tpu::*;
#(
   parameter int NUM_REQ     = NUM_DMEM_REQ,
   parameter int WDOG_CYCLES = 256
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] I_Req,
   input  address_t           I_Length    [NUM_REQ],
   input  address_t           I_Stride    [NUM_REQ],
   input  address_t           I_Base_Addr [NUM_REQ],
   input  logic               I_Beat,
   output logic [NUM_REQ-1:0] O_Grant,
   output logic               O_GrantVld,
   output logic [1:0]         O_GrantNo,
   output address_t           O_Length,
   output address_t           O_Stride,
   output address_t           O_Base_Addr,
   output logic               O_Start,
   output logic               O_End,
   output logic               O_Busy,
   output logic               O_Abort
);

   sched_state_t        state_q,   state_d;
   logic [1:0]          ptr_q,     ptr_d;
   logic [NUM_REQ-1:0]  grant_q,   grant_d;
   logic [1:0]          grantNo_q, grantNo_d;
   address_t            length_q,  length_d;
   address_t            stride_q,  stride_d;
   address_t            base_q,    base_d;
   address_t            count_q,   count_d;
   logic                pickVld;
   logic [1:0]          pickIdx;

`ifdef DMEM_SCHED_WATCHDOG_EN
   address_t            idle_q,    idle_d;
   logic                abort_q,   abort_d;
`endif

   dmem_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_i   (I_Req),
      .ptr_i   (ptr_q),
      .valid_o (pickVld),
      .idx_o   (pickIdx)
   );

   // Next-state logic: arbitrate in IDLE, configure in GRANT, count beats in RUN.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      grantNo_d = grantNo_q;
      length_d  = length_q;
      stride_d  = stride_q;
      base_d    = base_q;
      count_d   = count_q;
`ifdef DMEM_SCHED_WATCHDOG_EN
      idle_d    = idle_q;
      abort_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (pickVld) begin
               state_d          = GRANT;
               grant_d          = '0;
               grant_d[pickIdx] = 1'b1;
               grantNo_d        = pickIdx;
               length_d         = I_Length[pickIdx];
               stride_d         = I_Stride[pickIdx];
               base_d           = I_Base_Addr[pickIdx];
            end
         end
         GRANT: begin
            count_d = '0;
`ifdef DMEM_SCHED_WATCHDOG_EN
            idle_d  = '0;
`endif
            if (length_q == '0) begin
               state_d = RELEASE;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (I_Beat) begin
`ifdef DMEM_SCHED_WATCHDOG_EN
               idle_d = '0;
`endif
               if (count_q == length_q - address_t'(1)) begin
                  state_d = RELEASE;
               end else begin
                  count_d = count_q + address_t'(1);
               end
            end
`ifdef DMEM_SCHED_WATCHDOG_EN
            else if (idle_q == address_t'(WDOG_CYCLES - 1)) begin
               state_d = RELEASE;
               abort_d = 1'b1;
            end else begin
               idle_d = idle_q + address_t'(1);
            end
`endif
         end
         RELEASE: begin
            state_d = IDLE;
            grant_d = '0;
            if (grantNo_q == 2'(NUM_REQ - 1)) begin
               ptr_d = 2'd0;
            end else begin
               ptr_d = grantNo_q + 2'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; reset abandons any transfer.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= 2'd0;
         grant_q   <= '0;
         grantNo_q <= 2'd0;
         length_q  <= '0;
         stride_q  <= '0;
         base_q    <= '0;
         count_q   <= '0;
`ifdef DMEM_SCHED_WATCHDOG_EN
         idle_q    <= '0;
         abort_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         grantNo_q <= grantNo_d;
         length_q  <= length_d;
         stride_q  <= stride_d;
         base_q    <= base_d;
         count_q   <= count_d;
`ifdef DMEM_SCHED_WATCHDOG_EN
         idle_q    <= idle_d;
         abort_q   <= abort_d;
`endif
      end
   end

   assign O_Grant     = grant_q;
   assign O_GrantVld  = |grant_q;
   assign O_GrantNo   = grantNo_q;
   assign O_Length    = length_q;
   assign O_Stride    = stride_q;
   assign O_Base_Addr = base_q;
   assign O_Start     = (state_q == GRANT);
   assign O_End       = (state_q == RELEASE);
   assign O_Busy      = (state_q != IDLE);

`ifdef DMEM_SCHED_WATCHDOG_EN
   assign O_Abort = abort_q;
`else
   logic unusedWdog;
   assign unusedWdog = ^WDOG_CYCLES;
   assign O_Abort    = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_port_sched.sv
// Testbench for dmem_port_sched: directed scenarios plus randomized
// transfers checked against a transaction-level round-robin model.
// Build with DMEM_SCHED_WATCHDOG_EN to also exercise the watchdog.
module tb_dmem_port_sched;
   import pkg_tpu::*;

   localparam int NR = 3;
   localparam int WD = 8;
`ifdef DMEM_SCHED_WATCHDOG_EN
   localparam bit WDOG_ON = 1'b1;
`else
   localparam bit WDOG_ON = 1'b0;
`endif

   logic          clock;
   logic          reset;
   logic [NR-1:0] I_Req;
   address_t      I_Length    [NR];
   address_t      I_Stride    [NR];
   address_t      I_Base_Addr [NR];
   logic          I_Beat;
   logic [NR-1:0] O_Grant;
   logic          O_GrantVld;
   logic [1:0]    O_GrantNo;
   address_t      O_Length;
   address_t      O_Stride;
   address_t      O_Base_Addr;
   logic          O_Start;
   logic          O_End;
   logic          O_Busy;
   logic          O_Abort;

   int checks = 0;
   int errors = 0;
   int ptrModel = 0;

   dmem_port_sched #(
      .NUM_REQ     (NR),
      .WDOG_CYCLES (WD)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .I_Req       (I_Req),
      .I_Length    (I_Length),
      .I_Stride    (I_Stride),
      .I_Base_Addr (I_Base_Addr),
      .I_Beat      (I_Beat),
      .O_Grant     (O_Grant),
      .O_GrantVld  (O_GrantVld),
      .O_GrantNo   (O_GrantNo),
      .O_Length    (O_Length),
      .O_Stride    (O_Stride),
      .O_Base_Addr (O_Base_Addr),
      .O_Start     (O_Start),
      .O_End       (O_End),
      .O_Busy      (O_Busy),
      .O_Abort     (O_Abort)
   );

   // Free-running clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Round robin: first requester at or after the pointer, cyclically.
   function automatic int pickWinner(input logic [NR-1:0] req);
      for (int k = 0; k < NR; k++) begin
         int i;
         i = (ptrModel + k) % NR;
         if (req[i]) return i;
      end
      return 0;
   endfunction

   task automatic randomizeConfig();
      for (int i = 0; i < NR; i++) begin
         I_Length[i]    = $urandom_range(0, 6);
         I_Stride[i]    = $urandom;
         I_Base_Addr[i] = $urandom;
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".grant"},  32'(O_Grant),    32'd0);
      checkOutput({tag, ".vld"},    32'(O_GrantVld), 32'd0);
      checkOutput({tag, ".no"},     32'(O_GrantNo),  32'd0);
      checkOutput({tag, ".len"},    O_Length,        32'd0);
      checkOutput({tag, ".stride"}, O_Stride,        32'd0);
      checkOutput({tag, ".base"},   O_Base_Addr,     32'd0);
      checkOutput({tag, ".start"},  32'(O_Start),    32'd0);
      checkOutput({tag, ".end"},    32'(O_End),      32'd0);
      checkOutput({tag, ".busy"},   32'(O_Busy),     32'd0);
      checkOutput({tag, ".abort"},  32'(O_Abort),    32'd0);
   endtask

   // One complete transfer from IDLE back to IDLE; lenForce < 0 keeps random lengths.
   task automatic applyStimulus(input logic [NR-1:0] req, input int lenForce, input int beatPct);
      int       win;
      address_t expLen, expStride, expBase;
      int       beats, idle;
      bit       done, expAbort;
      randomizeConfig();
      if (lenForce >= 0) begin
         for (int i = 0; i < NR; i++) I_Length[i] = address_t'(lenForce);
      end
      I_Req     = req;
      I_Beat    = 1'($urandom_range(0, 1));
      win       = pickWinner(req);
      expLen    = I_Length[win];
      expStride = I_Stride[win];
      expBase   = I_Base_Addr[win];
      step();
      checkOutput("grant.onehot", 32'(O_Grant),   32'(1) << win);
      checkOutput("grant.vld",    32'(O_GrantVld), 32'd1);
      checkOutput("grant.no",     32'(O_GrantNo),  32'(win));
      checkOutput("grant.start",  32'(O_Start),    32'd1);
      checkOutput("grant.len",    O_Length,        expLen);
      checkOutput("grant.stride", O_Stride,        expStride);
      checkOutput("grant.base",   O_Base_Addr,     expBase);
      checkOutput("grant.busy",   32'(O_Busy),     32'd1);
      checkOutput("grant.end",    32'(O_End),      32'd0);
      // Requests, configuration and beats seen during GRANT must be ignored.
      I_Req  = NR'($urandom);
      randomizeConfig();
      I_Beat = 1'($urandom_range(0, 1));
      step();
      beats    = 0;
      idle     = 0;
      expAbort = 1'b0;
      done     = (expLen == 0);
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         checkOutput("run.end",   32'(O_End),     32'd0);
         checkOutput("run.start", 32'(O_Start),   32'd0);
         checkOutput("run.no",    32'(O_GrantNo), 32'(win));
         I_Beat = ($urandom_range(0, 99) < beatPct);
         I_Req  = NR'($urandom);
         if (I_Beat) begin
            beats++;
            idle = 0;
         end else begin
            idle++;
         end
         step();
         if (beats == int'(expLen)) begin
            done = 1'b1;
         end else if (WDOG_ON && idle == WD) begin
            done     = 1'b1;
            expAbort = 1'b1;
         end
      end
      checkOutput("run.bounded", 32'(done), 32'd1);
      checkOutput("rel.end",   32'(O_End),     32'd1);
      checkOutput("rel.abort", 32'(O_Abort),   32'(expAbort));
      checkOutput("rel.grant", 32'(O_Grant),   32'(1) << win);
      checkOutput("rel.no",    32'(O_GrantNo), 32'(win));
      checkOutput("rel.busy",  32'(O_Busy),    32'd1);
      I_Req  = '0;
      I_Beat = 1'($urandom_range(0, 1));
      step();
      checkOutput("idle.end",   32'(O_End),      32'd0);
      checkOutput("idle.grant", 32'(O_Grant),    32'd0);
      checkOutput("idle.vld",   32'(O_GrantVld), 32'd0);
      checkOutput("idle.busy",  32'(O_Busy),     32'd0);
      checkOutput("idle.abort", 32'(O_Abort),    32'd0);
      ptrModel = (win + 1) % NR;
   endtask

   // Start a length-5 transfer, accept two beats, then reset in the middle of RUN.
   task automatic resetMidRun();
      randomizeConfig();
      for (int i = 0; i < NR; i++) I_Length[i] = 32'd5;
      I_Req  = 3'b100;
      I_Beat = 1'b0;
      step();
      I_Req = '0;
      step();
      checkOutput("rst.inrun", 32'(O_Busy), 32'd1);
      I_Beat = 1'b1;
      step();
      step();
      checkOutput("rst.stillrun", 32'(O_End), 32'd0);
      reset = 1'b1;
      step();
      checkAllZero("rst.mid");
      reset  = 1'b0;
      I_Beat = 1'b0;
      ptrModel = 0;
      step();
      checkAllZero("rst.after");
   endtask

   // Test sequence: reset, directed scenarios, then randomized transfers.
   initial begin
      reset  = 1'b1;
      I_Req  = '0;
      I_Beat = 1'b0;
      randomizeConfig();
      step();
      step();
      checkAllZero("reset");
      reset = 1'b0;
      step();

      // Single transfer, four consecutive beats.
      applyStimulus(3'b001, 4, 100);
      // Round robin with all requesting.
      applyStimulus(3'b111, -1, 60);
      applyStimulus(3'b111, -1, 60);
      applyStimulus(3'b111, -1, 60);
      // Move pointer to 1, then 3'b101 must grant index 2.
      applyStimulus(3'b001, 2, 80);
      applyStimulus(3'b101, 3, 50);
      // Zero-length transfer.
      applyStimulus(3'b010, 0, 50);
      // Sparse beats with stray beats around GRANT.
      applyStimulus(3'b110, 5, 40);

      resetMidRun();
      applyStimulus(3'b111, 3, 70);

`ifdef DMEM_SCHED_WATCHDOG_EN
      // No beats at all: watchdog must abort after WD stalled cycles.
      applyStimulus(3'b001, 3, 0);
`endif

      for (int n = 0; n < 40; n++) begin
         applyStimulus(NR'($urandom_range(1, 7)), -1, 70);
         if ($urandom_range(0, 3) == 0) step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
